// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: memory geometry,
// the HALT opcode, opcode field position and the fetch FSM encoding.
package instr_fetch_unit_pkg;

  localparam int DEPTH = 10;
  localparam int WIDTH = 15;
  localparam int AW    = 4;

  localparam logic [4:0] HALT_OP = 5'b11111;
  localparam int OP_MSB = 14;
  localparam int OP_LSB = 10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_FETCH = 2'b01,
    ST_HALT  = 2'b10
  } state_t;

  function automatic logic [4:0] opcode(input logic [WIDTH-1:0] word);
    return word[OP_MSB:OP_LSB];
  endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Bus bundle between the fetch unit, the RAM read port 1 and the decode stage.
//   master : fetch unit side (drives RA, IR, VALID, PC, BUSY, FAULT)
//   slave  : environment side (drives START, STOP, BRV, BRT, RD, READY)
interface instr_fetch_unit_if;
  import instr_fetch_unit_pkg::*;

  logic             fetchunitSTART;
  logic             fetchunitSTOP;
  logic             fetchunitBRV;
  logic [AW-1:0]    fetchunitBRT;
  logic [AW-1:0]    fetchunitRA;
  logic [WIDTH-1:0] fetchunitRD;
  logic [WIDTH-1:0] fetchunitIR;
  logic             fetchunitVALID;
  logic             fetchunitREADY;
  logic [AW-1:0]    fetchunitPC;
  logic             fetchunitBUSY;
  logic             fetchunitFAULT;

  modport master (
    input  fetchunitSTART, fetchunitSTOP, fetchunitBRV, fetchunitBRT,
           fetchunitRD, fetchunitREADY,
    output fetchunitRA, fetchunitIR, fetchunitVALID, fetchunitPC,
           fetchunitBUSY, fetchunitFAULT
  );

  modport slave (
    output fetchunitSTART, fetchunitSTOP, fetchunitBRV, fetchunitBRT,
           fetchunitRD, fetchunitREADY,
    input  fetchunitRA, fetchunitIR, fetchunitVALID, fetchunitPC,
           fetchunitBUSY, fetchunitFAULT
  );

endinterface

// File: rtl/instr_fetch_unit_pc_counter.sv
// Program counter: modulo-DEPTH up-counter with parallel load.
//   clk, rst  : clock, asynchronous active-high reset
//   load      : load load_val (branch redirect), takes priority over inc
//   load_val  : branch target, already range-checked by the caller
//   inc       : advance by one, wrapping DEPTH-1 -> 0
//   count     : current program counter
module instr_fetch_unit_pc_counter
  import instr_fetch_unit_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [AW-1:0] load_val,
  input  logic          inc,
  output logic [AW-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (inc) begin
      count <= (count == AW'(DEPTH - 1)) ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage. Owns the PC, reads RAM port 1 combinationally
// through RA/RD, registers each word into IR and hands it to decode over
// VALID/READY. Handles branch redirects, START/STOP and the HALT opcode.
//   fetchunitCLK / fetchunitRST : clock, asynchronous active-high reset
//   bus (master)                : control, RAM read port and decode handshake
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
(
  input  logic         fetchunitCLK,
  input  logic         fetchunitRST,
  instr_fetch_unit_if.master bus
);

  state_t           state, state_nxt;
  logic [AW-1:0]    pc;
  logic [WIDTH-1:0] ir;
  logic [AW-1:0]    ir_pc;
  logic             valid;
  logic             fault;

  logic br_illegal;
  logic stop_act;
  logic br_legal;
  logic do_fetch;

  // Out-of-range targets would point the RAM at undriven words, so they
  // fault instead of loading the PC.
  assign br_illegal = bus.fetchunitBRV && (bus.fetchunitBRT >= AW'(DEPTH));
  assign stop_act   = (state == ST_FETCH) && bus.fetchunitSTOP;
  // STOP outranks a legal redirect; the redirect is dropped that cycle.
  assign br_legal   = bus.fetchunitBRV && !br_illegal && !stop_act;
  assign do_fetch   = (state == ST_FETCH) && !bus.fetchunitSTOP &&
                      !bus.fetchunitBRV && (!valid || bus.fetchunitREADY);

  instr_fetch_unit_pc_counter u_pc (
    .clk      (fetchunitCLK),
    .rst      (fetchunitRST),
    .load     (br_legal),
    .load_val (bus.fetchunitBRT),
    .inc      (do_fetch),
    .count    (pc)
  );

  always_ff @(posedge fetchunitCLK or posedge fetchunitRST) begin
    if (fetchunitRST) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (br_illegal) begin
      state_nxt = ST_HALT;
    end else if (stop_act) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE, ST_HALT: begin
          if (bus.fetchunitSTART && !fault) state_nxt = ST_FETCH;
        end
        ST_FETCH: begin
          if (do_fetch && (opcode(bus.fetchunitRD) == HALT_OP)) state_nxt = ST_HALT;
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge fetchunitCLK or posedge fetchunitRST) begin
    if (fetchunitRST) begin
      ir    <= '0;
      ir_pc <= '0;
      valid <= 1'b0;
      fault <= 1'b0;
    end else if (br_illegal) begin
      valid <= 1'b0;
      fault <= 1'b1;
    end else if (br_legal) begin
      valid <= 1'b0;
    end else if (do_fetch) begin
      ir    <= bus.fetchunitRD;
      ir_pc <= pc;
      valid <= 1'b1;
    end else if (bus.fetchunitREADY) begin
      valid <= 1'b0;
    end
  end

  assign bus.fetchunitRA    = pc;
  assign bus.fetchunitIR    = ir;
  assign bus.fetchunitPC    = ir_pc;
  assign bus.fetchunitVALID = valid;
  assign bus.fetchunitFAULT = fault;
  assign bus.fetchunitBUSY  = (state == ST_FETCH);

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;
  import instr_fetch_unit_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  instr_fetch_unit_if bus();

  instr_fetch_unit dut (
    .fetchunitCLK (clk),
    .fetchunitRST (rst),
    .bus          (bus)
  );

  logic [WIDTH-1:0] mem [0:15];
  assign bus.fetchunitRD = mem[bus.fetchunitRA];

  int n_checks = 0;
  int n_err    = 0;
  logic [18:0] sb[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push(input int a);
    sb.push_back({4'(a), mem[a]});
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Every accepted transfer must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst && bus.fetchunitVALID && bus.fetchunitREADY) begin
      if (sb.size() == 0) begin
        chk("spurious_out", 32'(bus.fetchunitVALID), 32'd0);
      end else begin
        chk("ir_pc", 32'({bus.fetchunitPC, bus.fetchunitIR}), 32'(sb.pop_front()));
      end
    end
  end

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 15'(i < DEPTH ? i : 0);
    bus.fetchunitSTART = 1'b0;
    bus.fetchunitSTOP  = 1'b0;
    bus.fetchunitBRV   = 1'b0;
    bus.fetchunitBRT   = '0;
    bus.fetchunitREADY = 1'b0;

    // reset state
    step(2);
    chk("rst_ir",    32'(bus.fetchunitIR), 32'd0);
    chk("rst_valid", 32'(bus.fetchunitVALID), 32'd0);
    chk("rst_ra",    32'(bus.fetchunitRA), 32'd0);
    chk("rst_pc",    32'(bus.fetchunitPC), 32'd0);
    chk("rst_busy",  32'(bus.fetchunitBUSY), 32'd0);
    chk("rst_fault", 32'(bus.fetchunitFAULT), 32'd0);
    rst = 1'b0;
    step(1);
    chk("idle_busy", 32'(bus.fetchunitBUSY), 32'd0);

    // streaming 0..9,0,1 with wrap
    for (int i = 0; i < 10; i++) push(i);
    push(0); push(1);
    bus.fetchunitSTART = 1'b1;
    bus.fetchunitREADY = 1'b1;
    step(1);
    chk("start_busy",  32'(bus.fetchunitBUSY), 32'd1);
    chk("start_valid", 32'(bus.fetchunitVALID), 32'd0);
    step(1);
    for (int i = 0; i < 12; i++) begin
      chk("stream_valid", 32'(bus.fetchunitVALID), 32'd1);
      if (i == 11) begin
        bus.fetchunitSTOP  = 1'b1;
        bus.fetchunitSTART = 1'b0;
      end
      step(1);
    end
    bus.fetchunitSTOP = 1'b0;
    chk("stop_busy",  32'(bus.fetchunitBUSY), 32'd0);
    chk("stop_valid", 32'(bus.fetchunitVALID), 32'd0);
    chk("stop_ra",    32'(bus.fetchunitRA), 32'd2);
    chk("drain1",     32'(sb.size()), 32'd0);

    // stall at word 4
    for (int i = 2; i <= 6; i++) push(i);
    bus.fetchunitSTART = 1'b1;
    step(1);
    bus.fetchunitSTART = 1'b0;
    step(3);
    chk("pre_stall_ir", 32'(bus.fetchunitIR), 32'd4);
    bus.fetchunitREADY = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(1);
      chk("stall_ir",    32'(bus.fetchunitIR), 32'd4);
      chk("stall_pc",    32'(bus.fetchunitPC), 32'd4);
      chk("stall_ra",    32'(bus.fetchunitRA), 32'd5);
      chk("stall_valid", 32'(bus.fetchunitVALID), 32'd1);
    end
    bus.fetchunitREADY = 1'b1;
    step(1);
    chk("post_stall_ir", 32'(bus.fetchunitIR), 32'd5);
    step(1);
    bus.fetchunitSTOP = 1'b1;
    step(1);
    bus.fetchunitSTOP = 1'b0;
    chk("drain2", 32'(sb.size()), 32'd0);

    // branch to 7 while stalled
    bus.fetchunitREADY = 1'b0;
    bus.fetchunitSTART = 1'b1;
    step(1);
    bus.fetchunitSTART = 1'b0;
    step(1);
    chk("br_pre_valid", 32'(bus.fetchunitVALID), 32'd1);
    chk("br_pre_ra",    32'(bus.fetchunitRA), 32'd8);
    bus.fetchunitBRV = 1'b1;
    bus.fetchunitBRT = 4'd7;
    step(1);
    bus.fetchunitBRV = 1'b0;
    chk("br_flush", 32'(bus.fetchunitVALID), 32'd0);
    chk("br_ra",    32'(bus.fetchunitRA), 32'd7);
    push(7); push(8);
    bus.fetchunitREADY = 1'b1;
    step(1);
    chk("br_tgt_valid", 32'(bus.fetchunitVALID), 32'd1);
    step(1);
    bus.fetchunitSTOP = 1'b1;
    step(1);
    bus.fetchunitSTOP = 1'b0;
    chk("drain3", 32'(sb.size()), 32'd0);

    // HALT opcode at word 3, then resume
    mem[3] = {HALT_OP, 10'h000};
    bus.fetchunitBRV = 1'b1;
    bus.fetchunitBRT = 4'd0;
    step(1);
    bus.fetchunitBRV = 1'b0;
    chk("halt_ra0", 32'(bus.fetchunitRA), 32'd0);
    for (int i = 0; i < 4; i++) push(i);
    bus.fetchunitSTART = 1'b1;
    step(1);
    bus.fetchunitSTART = 1'b0;
    step(4);
    chk("halt_busy",  32'(bus.fetchunitBUSY), 32'd0);
    chk("halt_ir",    32'(bus.fetchunitIR), 32'h7C00);
    step(1);
    chk("halt_consumed", 32'(bus.fetchunitVALID), 32'd0);
    step(2);
    chk("halt_nofetch", 32'(bus.fetchunitVALID), 32'd0);
    chk("halt_ra",      32'(bus.fetchunitRA), 32'd4);
    push(4); push(5);
    bus.fetchunitSTART = 1'b1;
    step(1);
    bus.fetchunitSTART = 1'b0;
    chk("resume_busy", 32'(bus.fetchunitBUSY), 32'd1);
    step(2);
    bus.fetchunitSTOP = 1'b1;
    step(1);
    bus.fetchunitSTOP = 1'b0;
    chk("drain4", 32'(sb.size()), 32'd0);
    mem[3] = 15'd3;

    // illegal branch
    bus.fetchunitREADY = 1'b0;
    bus.fetchunitSTART = 1'b1;
    step(1);
    bus.fetchunitSTART = 1'b0;
    step(1);
    chk("ill_pre_valid", 32'(bus.fetchunitVALID), 32'd1);
    bus.fetchunitBRV = 1'b1;
    bus.fetchunitBRT = 4'd12;
    step(1);
    bus.fetchunitBRV = 1'b0;
    chk("ill_fault", 32'(bus.fetchunitFAULT), 32'd1);
    chk("ill_busy",  32'(bus.fetchunitBUSY), 32'd0);
    chk("ill_valid", 32'(bus.fetchunitVALID), 32'd0);
    chk("ill_ra",    32'(bus.fetchunitRA), 32'd7);
    bus.fetchunitSTART = 1'b1;
    bus.fetchunitREADY = 1'b1;
    step(3);
    chk("ill_start_busy",  32'(bus.fetchunitBUSY), 32'd0);
    chk("ill_start_valid", 32'(bus.fetchunitVALID), 32'd0);
    chk("ill_start_fault", 32'(bus.fetchunitFAULT), 32'd1);
    bus.fetchunitSTART = 1'b0;
    #2 rst = 1'b1;
    #2;
    chk("ill_rst_fault", 32'(bus.fetchunitFAULT), 32'd0);
    rst = 1'b0;
    step(1);

    // async reset between edges while VALID
    bus.fetchunitREADY = 1'b0;
    bus.fetchunitBRV = 1'b1;
    bus.fetchunitBRT = 4'd5;
    step(1);
    bus.fetchunitBRV = 1'b0;
    bus.fetchunitSTART = 1'b1;
    step(1);
    bus.fetchunitSTART = 1'b0;
    step(1);
    chk("ar_pre_valid", 32'(bus.fetchunitVALID), 32'd1);
    chk("ar_pre_ir",    32'(bus.fetchunitIR), 32'd5);
    #2 rst = 1'b1;
    #1;
    chk("ar_valid", 32'(bus.fetchunitVALID), 32'd0);
    chk("ar_ir",    32'(bus.fetchunitIR), 32'd0);
    chk("ar_ra",    32'(bus.fetchunitRA), 32'd0);
    chk("ar_pc",    32'(bus.fetchunitPC), 32'd0);
    chk("ar_busy",  32'(bus.fetchunitBUSY), 32'd0);
    #2 rst = 1'b0;
    step(2);
    chk("ar_idle_busy",  32'(bus.fetchunitBUSY), 32'd0);
    chk("ar_idle_valid", 32'(bus.fetchunitVALID), 32'd0);
    chk("drain_final",   32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
